// File: rtl/myproject_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : myproject_mul_pkg
// Description : Shared constants and helper functions for the pipelined
//               multiplier family: product width, signed saturation bounds
//               and pipeline-depth legality.
// Revision    : 1.0 - initial release
// ============================================================================
package myproject_mul_pkg;

  // Legal pipeline depth range.
  localparam int MIN_NUM_STAGE = 1;
  localparam int MAX_NUM_STAGE = 4;

  // Width of the full signed product of a signed w0-bit operand and a
  // w1-bit operand. Zero-extending an unsigned w1 operand still fits in
  // w0+w1 bits because |a*b| < 2^(w0-1) * 2^w1.
  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1;
  endfunction

  // Largest value representable in a signed w-bit field (w <= 63).
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a signed w-bit field (w <= 63).
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // True when the requested pipeline depth is supported.
  function automatic bit num_stage_ok(input int n);
    return (n >= MIN_NUM_STAGE) && (n <= MAX_NUM_STAGE);
  endfunction

endpackage : myproject_mul_pkg
`default_nettype wire

// File: rtl/myproject_mul_pipe_post.sv
`default_nettype none
// ============================================================================
// Module      : myproject_mul_pipe_post
// Description : Combinational output scaling for a full-width signed product:
//               arithmetic right shift (floor) followed by either signed
//               saturation or low-bit wrap into the result width.
// Revision    : 1.0 - initial release
// ============================================================================
module myproject_mul_pipe_post
  import myproject_mul_pkg::*;
#(
  parameter int P          = 22,
  parameter int SHIFT      = 0,
  parameter int dout_WIDTH = 22,
  parameter int SAT        = 0
) (
  input  logic signed [P-1:0]          prod,
  output logic signed [dout_WIDTH-1:0] res
);

  // Working width wide enough for both the product and the result, so the
  // sign-extension case and the narrowing case share one datapath.
  localparam int W  = (P > dout_WIDTH) ? P : dout_WIDTH;
  // Number of significant bits left after the shift.
  localparam int SW = P - SHIFT;

  logic signed [P-1:0] shifted;
  logic signed [W-1:0] wide;

  // Arithmetic shift drops low bits, which floors toward minus infinity.
  assign shifted = prod >>> SHIFT;

  generate
    if (W > P) begin : g_widen
      assign wide = {{(W - P){shifted[P-1]}}, shifted};
    end else begin : g_same
      assign wide = shifted;
    end
  endgenerate

  generate
    if ((SAT != 0) && (SW > dout_WIDTH)) begin : g_sat
      localparam logic signed [W-1:0] C_MAX = W'(sat_max(dout_WIDTH));
      localparam logic signed [W-1:0] C_MIN = W'(sat_min(dout_WIDTH));

      // Clamp out-of-range values to the signed result range.
      always_comb begin
        res = dout_WIDTH'(wide);
        if (wide > C_MAX) begin
          res = dout_WIDTH'(C_MAX);
        end else if (wide < C_MIN) begin
          res = dout_WIDTH'(C_MIN);
        end
      end
    end else begin : g_wrap
      // Either the value always fits (sign-extended) or low bits are kept.
      assign res = dout_WIDTH'(wide);
    end
  endgenerate

endmodule : myproject_mul_pipe_post
`default_nettype wire

// File: rtl/myproject_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : myproject_mul_pipe
// Description : Parametrised pipelined signed x (un)signed multiplier with
//               clock enable, travelling valid bit, output shift and
//               saturate/wrap. Latency equals NUM_STAGE enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module myproject_mul_pipe
  import myproject_mul_pkg::*;
#(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int din0_WIDTH  = 16,
  parameter int din1_WIDTH  = 6,
  parameter int din1_SIGNED = 0,
  parameter int dout_WIDTH  = 22,
  parameter int SHIFT       = 0,
  parameter int SAT         = 0
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         ce,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0]        din1,
  input  logic                         din_vld,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         dout_vld
);

  localparam int P = prod_width(din0_WIDTH, din1_WIDTH);

  // Refuse to elaborate an unsupported pipeline depth (ID is a free tag but
  // must still be a sensible non-negative number).
  generate
    if (!num_stage_ok(NUM_STAGE) || (ID < 0)) begin : g_bad_param
      $fatal(1, "myproject_mul_pipe: NUM_STAGE must be 1..4 and ID >= 0");
    end
  endgenerate

  logic signed [din0_WIDTH-1:0] mul_a;
  logic [din1_WIDTH-1:0]        mul_b;
  logic                         b_fill;
  logic signed [P-1:0]          a_ext;
  logic signed [P-1:0]          b_ext;
  logic signed [P-1:0]          prod_c;
  logic signed [P-1:0]          post_in;
  logic signed [dout_WIDTH-1:0] post_out;
  logic [NUM_STAGE-1:0]         vld_sr;

  // ---------------------------------------------------------------------
  // Operand source: registered for depths >= 2, direct for depth 1.
  // ---------------------------------------------------------------------
  generate
    if (NUM_STAGE >= 2) begin : g_in_reg
      logic signed [din0_WIDTH-1:0] a_r;
      logic [din1_WIDTH-1:0]        b_r;

      // Input register: loads every enabled cycle, valid or not.
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          a_r <= '0;
          b_r <= '0;
        end else if (ce) begin
          a_r <= din0;
          b_r <= din1;
        end
      end

      assign mul_a = a_r;
      assign mul_b = b_r;
    end else begin : g_in_comb
      assign mul_a = din0;
      assign mul_b = din1;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Multiply. Both operands are extended to the full product width; since
  // the true product always fits in P bits, the P-bit product is exact.
  // ---------------------------------------------------------------------
  assign b_fill = (din1_SIGNED != 0) ? mul_b[din1_WIDTH-1] : 1'b0;
  assign a_ext  = {{din1_WIDTH{mul_a[din0_WIDTH-1]}}, mul_a};
  assign b_ext  = {{din0_WIDTH{b_fill}}, mul_b};
  assign prod_c = a_ext * b_ext;

  // ---------------------------------------------------------------------
  // Product registers: one for depth 3, two for depth 4 (retiming slack).
  // ---------------------------------------------------------------------
  generate
    if (NUM_STAGE >= 3) begin : g_prod_reg
      logic signed [P-1:0] p1_r;

      // First product register.
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          p1_r <= '0;
        end else if (ce) begin
          p1_r <= prod_c;
        end
      end

      if (NUM_STAGE == 4) begin : g_prod_retime
        logic signed [P-1:0] p2_r;

        // Extra product register for multiplier retiming.
        always_ff @(posedge ap_clk) begin
          if (ap_rst) begin
            p2_r <= '0;
          end else if (ce) begin
            p2_r <= p1_r;
          end
        end

        assign post_in = p2_r;
      end else begin : g_prod_single
        assign post_in = p1_r;
      end
    end else begin : g_prod_comb
      assign post_in = prod_c;
    end
  endgenerate

  // Shift and saturate/wrap ahead of the output register.
  myproject_mul_pipe_post #(
    .P          (P),
    .SHIFT      (SHIFT),
    .dout_WIDTH (dout_WIDTH),
    .SAT        (SAT)
  ) u_post (
    .prod (post_in),
    .res  (post_out)
  );

  // Output data register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dout <= '0;
    end else if (ce) begin
      dout <= post_out;
    end
  end

  // ---------------------------------------------------------------------
  // Valid shift register: advances with ce, din_vld enters at stage 1.
  // ---------------------------------------------------------------------
  generate
    if (NUM_STAGE == 1) begin : g_vld_one
      // Single valid stage aligned with the output register.
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          vld_sr <= '0;
        end else if (ce) begin
          vld_sr <= din_vld;
        end
      end
    end else begin : g_vld_shift
      // Valid bit travels alongside the data stages.
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          vld_sr <= '0;
        end else if (ce) begin
          vld_sr <= {vld_sr[NUM_STAGE-2:0], din_vld};
        end
      end
    end
  endgenerate

  assign dout_vld = vld_sr[NUM_STAGE-1];

endmodule : myproject_mul_pipe
`default_nettype wire

// File: tb/tb_myproject_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_myproject_mul_pipe
// Description : Directed self-checking bench for myproject_mul_pipe across
//               default, depth-1, depth-4, saturating, wrapping and
//               signed-din1 configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_myproject_mul_pipe;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [15:0] din0;
  logic [5:0]  din1;
  logic        vld;

  logic [21:0] dout_def, dout_s1, dout_s4, dout_sgn;
  logic [15:0] dout_sat, dout_wrap;
  logic        vld_def, vld_s1, vld_s4, vld_sgn, vld_sat, vld_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  myproject_mul_pipe u_def (
    .ap_clk(clk), .ap_rst(rst), .ce(ce), .din0(din0), .din1(din1),
    .din_vld(vld), .dout(dout_def), .dout_vld(vld_def)
  );

  myproject_mul_pipe #(.NUM_STAGE(1)) u_s1 (
    .ap_clk(clk), .ap_rst(rst), .ce(ce), .din0(din0), .din1(din1),
    .din_vld(vld), .dout(dout_s1), .dout_vld(vld_s1)
  );

  myproject_mul_pipe #(.NUM_STAGE(4)) u_s4 (
    .ap_clk(clk), .ap_rst(rst), .ce(ce), .din0(din0), .din1(din1),
    .din_vld(vld), .dout(dout_s4), .dout_vld(vld_s4)
  );

  myproject_mul_pipe #(.dout_WIDTH(16), .SHIFT(4), .SAT(1)) u_sat (
    .ap_clk(clk), .ap_rst(rst), .ce(ce), .din0(din0), .din1(din1),
    .din_vld(vld), .dout(dout_sat), .dout_vld(vld_sat)
  );

  myproject_mul_pipe #(.dout_WIDTH(16), .SHIFT(4), .SAT(0)) u_wrap (
    .ap_clk(clk), .ap_rst(rst), .ce(ce), .din0(din0), .din1(din1),
    .din_vld(vld), .dout(dout_wrap), .dout_vld(vld_wrap)
  );

  myproject_mul_pipe #(.din1_SIGNED(1)) u_sgn (
    .ap_clk(clk), .ap_rst(rst), .ce(ce), .din0(din0), .din1(din1),
    .din_vld(vld), .dout(dout_sgn), .dout_vld(vld_sgn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; vld = 1'b1; din0 = 16'h1234; din1 = 6'd7;
    step(); step(); step(); step();
    n_checks++;
    if (dout_def !== 22'd0 || vld_def !== 1'b0) begin
      n_fail++; $display("FAIL reset_def: dout=%h vld=%b want 0 0", dout_def, vld_def);
    end
    n_checks++;
    if (dout_s1 !== 22'd0 || vld_s1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_s1: dout=%h vld=%b want 0 0", dout_s1, vld_s1);
    end
    n_checks++;
    if (dout_s4 !== 22'd0 || vld_s4 !== 1'b0) begin
      n_fail++; $display("FAIL reset_s4: dout=%h vld=%b want 0 0", dout_s4, vld_s4);
    end
    n_checks++;
    if (dout_sat !== 16'd0 || vld_sat !== 1'b0 || dout_wrap !== 16'd0 || vld_wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_scaled: sat=%h/%b wrap=%h/%b want 0", dout_sat, vld_sat, dout_wrap, vld_wrap);
    end
    n_checks++;
    if (dout_sgn !== 22'd0 || vld_sgn !== 1'b0) begin
      n_fail++; $display("FAIL reset_sgn: dout=%h vld=%b want 0 0", dout_sgn, vld_sgn);
    end
    rst = 1'b0; vld = 1'b0; din0 = '0; din1 = '0;
    step(); step(); step(); step();
  endtask

  // One valid sample, then bubbles; checks latency for depths 1, 3 and 4.
  task automatic test_defaults();
    for (int c = 0; c < 6; c++) begin
      din0 = (c == 0) ? 16'h8000 : 16'h0000;
      din1 = (c == 0) ? 6'd63 : 6'd0;
      vld  = (c == 0);
      step();
      n_checks++;
      if (vld_def !== 1'(c == 2)) begin
        n_fail++; $display("FAIL defaults_vld c=%0d: got %b want %b", c, vld_def, (c == 2));
      end
      n_checks++;
      if (vld_s1 !== 1'(c == 0)) begin
        n_fail++; $display("FAIL s1_vld c=%0d: got %b want %b", c, vld_s1, (c == 0));
      end
      n_checks++;
      if (vld_s4 !== 1'(c == 3)) begin
        n_fail++; $display("FAIL s4_vld c=%0d: got %b want %b", c, vld_s4, (c == 3));
      end
      if (c == 2) begin
        n_checks++;
        if (dout_def !== 22'h208000) begin
          n_fail++; $display("FAIL defaults_dout: got %h want 208000", dout_def);
        end
      end
      if (c == 0) begin
        n_checks++;
        if (dout_s1 !== 22'h208000) begin
          n_fail++; $display("FAIL s1_dout: got %h want 208000", dout_s1);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (dout_s4 !== 22'h208000) begin
          n_fail++; $display("FAIL s4_dout: got %h want 208000", dout_s4);
        end
      end
    end
  endtask

  task automatic test_streaming();
    logic [15:0] a [4];
    logic [5:0]  b [4];
    logic [21:0] e [4];
    a = '{16'd1, 16'd2, 16'hFFFD, 16'd7};
    b = '{6'd1, 6'd2, 6'd5, 6'd0};
    e = '{22'd1, 22'd4, 22'h3FFFF1, 22'd0};
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        din0 = a[c]; din1 = b[c]; vld = 1'b1;
      end else begin
        din0 = '0; din1 = '0; vld = 1'b0;
      end
      step();
      n_checks++;
      if (vld_def !== 1'(c >= 2 && c <= 5)) begin
        n_fail++; $display("FAIL stream_vld c=%0d: got %b want %b", c, vld_def, (c >= 2 && c <= 5));
      end
      if (c >= 2 && c <= 5) begin
        n_checks++;
        if (dout_def !== e[c-2]) begin
          n_fail++; $display("FAIL stream_dout c=%0d: got %h want %h", c, dout_def, e[c-2]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] a [4];
    logic [5:0]  b [4];
    logic [21:0] e [4];
    int          in_idx;
    int          out_idx;
    a = '{16'd1, 16'd2, 16'hFFFD, 16'd7};
    b = '{6'd1, 6'd2, 6'd5, 6'd0};
    e = '{22'd1, 22'd4, 22'h3FFFF1, 22'd0};
    // Fill the data path with a known product (3*3) carried by bubbles.
    din0 = 16'd3; din1 = 6'd3; vld = 1'b0; ce = 1'b1;
    step(); step(); step();
    for (int c = 0; c < 10; c++) begin
      ce = !(c == 2 || c == 3);
      in_idx  = (c == 0) ? 0 : (c == 1) ? 1 : (c == 4) ? 2 : (c == 5) ? 3 : -1;
      out_idx = (c >= 4 && c <= 7) ? c - 4 : -1;
      if (in_idx >= 0) begin
        din0 = a[in_idx]; din1 = b[in_idx]; vld = 1'b1;
      end else if (!ce) begin
        // Valid-looking data while stalled must be ignored.
        din0 = 16'h1234; din1 = 6'd9; vld = 1'b1;
      end else begin
        din0 = '0; din1 = '0; vld = 1'b0;
      end
      step();
      n_checks++;
      if (vld_def !== 1'(out_idx >= 0)) begin
        n_fail++; $display("FAIL stall_vld c=%0d: got %b want %b", c, vld_def, (out_idx >= 0));
      end
      if (out_idx >= 0) begin
        n_checks++;
        if (dout_def !== e[out_idx]) begin
          n_fail++; $display("FAIL stall_dout c=%0d: got %h want %h", c, dout_def, e[out_idx]);
        end
      end
      if (c == 2 || c == 3) begin
        n_checks++;
        if (dout_def !== 22'd9) begin
          n_fail++; $display("FAIL stall_hold c=%0d: got %h want 9", c, dout_def);
        end
      end
    end
    ce = 1'b1;
  endtask

  task automatic test_reset_midflight();
    din0 = 16'd11; din1 = 6'd2; vld = 1'b1; step();
    din0 = 16'd13; din1 = 6'd3; vld = 1'b1; step();
    // Reset wins even with ce low.
    rst = 1'b1; ce = 1'b0; vld = 1'b0; din0 = '0; din1 = '0;
    step();
    n_checks++;
    if (dout_def !== 22'd0 || vld_def !== 1'b0) begin
      n_fail++; $display("FAIL midreset_clear: dout=%h vld=%b want 0 0", dout_def, vld_def);
    end
    rst = 1'b0; ce = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (vld_def !== 1'b0) begin
        n_fail++; $display("FAIL midreset_drop c=%0d: vld got %b want 0", c, vld_def);
      end
    end
    din0 = 16'd5; din1 = 6'd3; vld = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      din0 = '0; din1 = '0; vld = 1'b0;
      n_checks++;
      if (vld_def !== 1'(c == 2)) begin
        n_fail++; $display("FAIL midreset_new_vld c=%0d: got %b want %b", c, vld_def, (c == 2));
      end
    end
    n_checks++;
    if (dout_def !== 22'd15) begin
      n_fail++; $display("FAIL midreset_new_dout: got %h want f", dout_def);
    end
  endtask

  task automatic test_scaling();
    logic [15:0] a  [5];
    logic [5:0]  b  [5];
    logic [15:0] es [5];
    logic [15:0] ew [5];
    a  = '{16'd32767, 16'h8000, 16'd100, 16'hFFFF, 16'hFF9C};
    b  = '{6'd63, 6'd63, 6'd3, 6'd1, 6'd3};
    es = '{16'h7FFF, 16'h8000, 16'h0012, 16'hFFFF, 16'hFFED};
    ew = '{16'hF7FC, 16'h0800, 16'h0012, 16'hFFFF, 16'hFFED};
    for (int c = 0; c < 8; c++) begin
      if (c < 5) begin
        din0 = a[c]; din1 = b[c]; vld = 1'b1;
      end else begin
        din0 = '0; din1 = '0; vld = 1'b0;
      end
      step();
      if (c >= 2 && c <= 6) begin
        n_checks++;
        if (vld_sat !== 1'b1 || dout_sat !== es[c-2]) begin
          n_fail++; $display("FAIL scale_sat c=%0d: got %h/%b want %h/1", c, dout_sat, vld_sat, es[c-2]);
        end
        n_checks++;
        if (vld_wrap !== 1'b1 || dout_wrap !== ew[c-2]) begin
          n_fail++; $display("FAIL scale_wrap c=%0d: got %h/%b want %h/1", c, dout_wrap, vld_wrap, ew[c-2]);
        end
      end
    end
  endtask

  task automatic test_signed();
    logic [15:0] a  [3];
    logic [5:0]  b  [3];
    logic [21:0] eg [3];
    logic [21:0] eu [3];
    a  = '{16'd100, 16'h8000, 16'd7};
    b  = '{6'b111111, 6'b100000, 6'b000101};
    eg = '{22'h3FFF9C, 22'h100000, 22'h000023};
    eu = '{22'h00189C, 22'h300000, 22'h000023};
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        din0 = a[c]; din1 = b[c]; vld = 1'b1;
      end else begin
        din0 = '0; din1 = '0; vld = 1'b0;
      end
      step();
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if (vld_sgn !== 1'b1 || dout_sgn !== eg[c-2]) begin
          n_fail++; $display("FAIL signed_din1 c=%0d: got %h/%b want %h/1", c, dout_sgn, vld_sgn, eg[c-2]);
        end
        n_checks++;
        if (vld_def !== 1'b1 || dout_def !== eu[c-2]) begin
          n_fail++; $display("FAIL unsigned_din1 c=%0d: got %h/%b want %h/1", c, dout_def, vld_def, eu[c-2]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; vld = 1'b0; din0 = '0; din1 = '0;
    test_reset();
    test_defaults();
    test_streaming();
    test_stall();
    test_reset_midflight();
    test_scaling();
    test_signed();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_myproject_mul_pipe
`default_nettype wire

// File: doc/myproject_mul_pipe.md
# myproject_mul_pipe

Parametrised, pipelined signed-by-(un)signed multiplier for the generated inference datapath. It supersedes the fixed-width single-cycle multiplier cells: operand widths, signedness of the second operand, pipeline depth, output scaling and overflow mode are all parameters. A clock-enable and a valid bit travel with the data, so upstream layers can stall and stream through it.

## Interface
- `ID`, default 1: instance tag; no functional effect.
- `NUM_STAGE`, default 3: register stages, legal range 1..4. This equals the latency in enabled cycles.
- `din0_WIDTH`, default 16: width of `din0`, which is always signed.
- `din1_WIDTH`, default 6: width of `din1`.
- `din1_SIGNED`, default 0: 0 zero-extends `din1`; 1 treats `din1` as two's complement.
- `dout_WIDTH`, default 22: result width, always signed.
- `SHIFT`, default 0: arithmetic right shift applied to the full product (floor), range 0..din0_WIDTH+din1_WIDTH-1.
- `SAT`, default 0: 0 wraps (keeps low bits); 1 saturates to the signed `dout_WIDTH` range.

Ports:
- `ap_clk` in 1: clock. One clock domain only.
- `ap_rst` in 1: synchronous, active-high reset.
- `ce` in 1: pipeline enable. When low, all state holds.
- `din0` in din0_WIDTH: multiplicand.
- `din1` in din1_WIDTH: multiplier.
- `din_vld` in 1: marks `din0`/`din1` as valid. It is sampled only when `ce` is high.
- `dout` out dout_WIDTH: scaled product, registered.
- `dout_vld` out 1: `dout` carries a valid result.

## Operation
- Full product width is P = din0_WIDTH + din1_WIDTH. Compute `din0` times `din1`, with `din1` zero- or sign-extended per `din1_SIGNED`.
- Arithmetic shift right by `SHIFT`. Truncation rounds toward minus infinity.
- Post-scale overflow when P-SHIFT > dout_WIDTH:
  - `SAT`=1: clamp to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
  - `SAT`=0: keep the low `dout_WIDTH` bits.
- If P-SHIFT ≤ dout_WIDTH, sign-extend the result.
- Valid pipeline: a `NUM_STAGE`-bit shift register. It advances only when `ce`=1, and `din_vld` enters at stage 1.
- Data registers load on every enabled cycle, whether or not the data is valid. `dout` is meaningful only when `dout_vld`=1.
- Stage placement:
  - `NUM_STAGE`=1: multiply, shift and saturate are combinational into the single output register.
  - `NUM_STAGE`=2: input register, then multiply, shift and saturate into the output register.
  - `NUM_STAGE`=3: input register, product register, then shift and saturate into the output register.
  - `NUM_STAGE`=4: an extra product register is added for DSP retiming.
- No back-pressure port. The consumer stalls by dropping `ce`.

## Timing
- Reset: on a clock edge with `ap_rst`=1, every valid bit, `dout_vld` and `dout` clear to 0. All pipeline data registers also clear to 0.
- Reset overrides `ce`. Items in flight when reset is asserted are discarded and never appear at the output.
- Latency: a sample accepted at enabled edge k appears on `dout`/`dout_vld` after enabled edge k+NUM_STAGE-1. With `ce` held high this is exactly `NUM_STAGE` cycles after presentation.
- Throughput: one result per enabled cycle. Back-to-back inputs produce back-to-back outputs in the same order.
- `ce`=0 for n cycles: `dout` and `dout_vld` hold their values, and latency stretches by exactly n. No sample is dropped or duplicated.
- `din_vld`=0 creates a bubble, which emerges as `dout_vld`=0 in the same slot.

## Structure
- Shared package `myproject_mul_pkg` holds:
  - the localparam function computing P;
  - the saturation bounds function `sat_max(w)` / `sat_min(w)`;
  - the `NUM_STAGE` legality check, which fails elaboration outside 1..4.
- Sub-module `myproject_mul_pipe_post`: combinational shift plus saturate/wrap, parametrised on P, `SHIFT`, `dout_WIDTH` and `SAT`. It is reused by future accumulate variants.
- Top level: input regs, product regs, valid shift register, output reg.

## Test plan
1. Defaults. `din0`=-32768, `din1`=63, `din_vld`=1 for one cycle, `ce`=1.
   - Expect `dout`=0x208000 (-2064384) with `dout_vld`=1 exactly 3 cycles later, and `dout_vld`=0 on the neighbouring cycles.
2. Streaming. Four consecutive inputs (1,1), (2,2), (-3,5), (7,0).
   - Expect 1, 4, -15, 0 on four consecutive cycles starting at cycle 3.
3. Stall. Same stream as test 2, with `ce`=0 for 2 cycles after the second input.
   - Expect outputs identical in value and order, each shifted by 2 cycles.
   - `dout` holds its value while stalled.
4. Reset mid-flight. Assert `ap_rst` for 1 cycle while 2 samples are in flight.
   - Next cycle `dout`=0 and `dout_vld`=0.
   - Neither sample ever emerges.
   - A new sample after reset has normal latency.
5. Scaling. Parameters `dout_WIDTH`=16, `SHIFT`=4.
   - `SAT`=1: `din0`=32767, `din1`=63 → 32767; `din0`=-32768, `din1`=63 → -32768.
   - `SAT`=0: `din0`=32767, `din1`=63 → 0xF7FC.
6. Signed `din1`. Parameter `din1_SIGNED`=1, `din0`=100, `din1`=6'b111111 → `dout`=0x3FFF9C (-100).
